// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute controller for the microcontroller datapath.
// Outputs are a combinational decode of the state register and IR fields.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        mfc,
  output logic        pc_out,
  output logic        pc_inc,
  output logic        ir_en,
  output logic        mar_en,
  output logic        mdr_en_write,
  output logic        mdr_en_read,
  output logic        mdr_out,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        alu_in1,
  output logic        alu_in2,
  output logic        alu_outlatch,
  output logic        alu_out_en,
  output logic [3:0]  g_in,
  output logic [3:0]  g_out,
  output logic        p0_in,
  output logic        p1_out,
  output logic        imm_out,
  output logic        halted
);

  localparam logic [3:0] S_F0   = 4'd0;
  localparam logic [3:0] S_F1   = 4'd1;
  localparam logic [3:0] S_F2   = 4'd2;
  localparam logic [3:0] S_DEC  = 4'd3;
  localparam logic [3:0] S_X0   = 4'd4;
  localparam logic [3:0] S_X1   = 4'd5;
  localparam logic [3:0] S_X2   = 4'd6;
  localparam logic [3:0] S_X3   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_IN    = 3'b010;
  localparam logic [2:0] OP_OUT   = 3'b011;
  localparam logic [2:0] OP_LDI   = 3'b100;
  localparam logic [2:0] OP_HALT  = 3'b111;

  logic [3:0] state, state_nxt;
  logic       active;

  logic       cls;
  logic [2:0] op;
  logic [3:0] d_sel, a_sel, b_sel;

  assign cls   = ir[15];
  assign op    = ir[14:12];
  assign d_sel = 4'b0001 << ir[11:10];
  assign a_sel = 4'b0001 << ir[9:8];
  assign b_sel = 4'b0001 << ir[7:6];

  // active holds F0 for one full cycle after reset release, so the first
  // edge after rst deasserts is the one that exposes the F0 decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) active <= 1'b0;
    else      active <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        state <= S_F0;
    else if (active) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_F0:  state_nxt = S_F1;
      S_F1:  state_nxt = mfc ? S_F2 : S_F1;
      S_F2:  state_nxt = S_DEC;
      S_DEC: begin
        if (!cls) state_nxt = S_X0;
        else begin
          case (op)
            OP_LOAD, OP_STORE, OP_IN, OP_OUT, OP_LDI: state_nxt = S_X0;
            OP_HALT: state_nxt = S_HALT;
            default: state_nxt = S_F0;
          endcase
        end
      end
      S_X0: begin
        if (!cls || op == OP_LOAD || op == OP_STORE) state_nxt = S_X1;
        else                                         state_nxt = S_F0;
      end
      S_X1: begin
        if (cls && op == OP_LOAD) state_nxt = mfc ? S_X2 : S_X1;
        else                      state_nxt = S_X2;
      end
      S_X2: begin
        if (!cls)                  state_nxt = S_X3;
        else if (op == OP_STORE)   state_nxt = mfc ? S_F0 : S_X2;
        else                       state_nxt = S_F0;
      end
      S_X3:   state_nxt = S_F0;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_F0;
    endcase
  end

  // Everything gated by active: outputs are zero while rst is low, which
  // also drops a pending memory request without waiting for a clock edge.
  always_comb begin
    pc_out       = 1'b0;
    pc_inc       = 1'b0;
    ir_en        = 1'b0;
    mar_en       = 1'b0;
    mdr_en_write = 1'b0;
    mdr_en_read  = 1'b0;
    mdr_out      = 1'b0;
    mem_en       = 1'b0;
    mem_rw       = 1'b0;
    alu_in1      = 1'b0;
    alu_in2      = 1'b0;
    alu_outlatch = 1'b0;
    alu_out_en   = 1'b0;
    g_in         = 4'b0000;
    g_out        = 4'b0000;
    p0_in        = 1'b0;
    p1_out       = 1'b0;
    imm_out      = 1'b0;
    halted       = 1'b0;
    if (active) begin
      case (state)
        S_F0: begin
          pc_out = 1'b1;
          mar_en = 1'b1;
        end
        S_F1: begin
          mem_en      = 1'b1;
          mem_rw      = 1'b1;
          mdr_en_read = mfc;
        end
        S_F2: begin
          mdr_out = 1'b1;
          ir_en   = 1'b1;
          pc_inc  = 1'b1;
        end
        S_X0: begin
          if (!cls) begin
            g_out   = a_sel;
            alu_in1 = 1'b1;
          end else begin
            case (op)
              OP_LOAD, OP_STORE: begin
                g_out  = a_sel;
                mar_en = 1'b1;
              end
              OP_IN: begin
                p1_out = 1'b1;
                g_in   = d_sel;
              end
              OP_OUT: begin
                g_out = a_sel;
                p0_in = 1'b1;
              end
              OP_LDI: begin
                imm_out = 1'b1;
                g_in    = d_sel;
              end
              default: ;
            endcase
          end
        end
        S_X1: begin
          if (!cls) begin
            g_out   = b_sel;
            alu_in2 = 1'b1;
          end else if (op == OP_LOAD) begin
            mem_en      = 1'b1;
            mem_rw      = 1'b1;
            mdr_en_read = mfc;
          end else if (op == OP_STORE) begin
            g_out        = b_sel;
            mdr_en_write = 1'b1;
          end
        end
        S_X2: begin
          if (!cls) begin
            alu_outlatch = 1'b1;
          end else if (op == OP_LOAD) begin
            mdr_out = 1'b1;
            g_in    = d_sel;
          end else if (op == OP_STORE) begin
            mem_en = 1'b1;
            mem_rw = 1'b0;
          end
        end
        S_X3: begin
          alu_out_en = 1'b1;
          g_in       = d_sel;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench: per-instruction cycle expectations are queued with the
// mfc to drive that cycle, then popped and compared one cycle at a time.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        mfc;
  logic        pc_out, pc_inc, ir_en, mar_en, mdr_en_write, mdr_en_read, mdr_out;
  logic        mem_en, mem_rw, alu_in1, alu_in2, alu_outlatch, alu_out_en;
  logic [3:0]  g_in, g_out;
  logic        p0_in, p1_out, imm_out, halted;

  control_unit dut (
    .clk(clk), .rst(rst), .ir(ir), .mfc(mfc),
    .pc_out(pc_out), .pc_inc(pc_inc), .ir_en(ir_en), .mar_en(mar_en),
    .mdr_en_write(mdr_en_write), .mdr_en_read(mdr_en_read), .mdr_out(mdr_out),
    .mem_en(mem_en), .mem_rw(mem_rw), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_outlatch(alu_outlatch), .alu_out_en(alu_out_en),
    .g_in(g_in), .g_out(g_out), .p0_in(p0_in), .p1_out(p1_out),
    .imm_out(imm_out), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef logic [24:0] ov_t;
  localparam int PCO = 24, PCI = 23, IRE = 22, MAR = 21, MDW = 20, MDR = 19;
  localparam int MDO = 18, MEN = 17, MRW = 16, A1 = 15, A2 = 14, AL = 13, AO = 12;
  localparam int GI = 8, GO = 4, P0 = 3, P1 = 2, IMM = 1, HLT = 0;

  typedef struct { logic m; ov_t exp; string tag; } sb_t;
  typedef struct { logic [15:0] ir; int wf; int wm; string name; } vec_t;

  sb_t  sbq[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  function automatic ov_t b(int n);
    ov_t v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  function automatic ov_t sample();
    return {pc_out, pc_inc, ir_en, mar_en, mdr_en_write, mdr_en_read, mdr_out,
            mem_en, mem_rw, alu_in1, alu_in2, alu_outlatch, alu_out_en,
            g_in, g_out, p0_in, p1_out, imm_out, halted};
  endfunction

  task automatic check(input string name, input ov_t act, input ov_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %07h expected %07h", name, act, exp);
    end
  endtask

  task automatic check_bus(input string name);
    checks++;
    if ($countones({pc_out, mdr_out, alu_out_en, p1_out, imm_out, g_out}) > 1) begin
      errors++;
      $display("FAIL bus_%s: drivers pc=%b mdr=%b alu=%b p1=%b imm=%b g=%b required at most one",
               name, pc_out, mdr_out, alu_out_en, p1_out, imm_out, g_out);
    end
  endtask

  task automatic push(input logic m, input ov_t e, input string t);
    sb_t s;
    s.m = m; s.exp = e; s.tag = t;
    sbq.push_back(s);
  endtask

  task automatic push_fetch(input int wf);
    push(1'b1, b(PCO) | b(MAR), "F0");
    repeat (wf) push(1'b0, b(MEN) | b(MRW), "F1_wait");
    push(1'b1, b(MEN) | b(MRW) | b(MDR), "F1");
    push(1'b1, b(MDO) | b(IRE) | b(PCI), "F2");
    push(1'b1, '0, "DECODE");
  endtask

  task automatic push_exec(input logic [15:0] i, input int wm);
    int d, a, bb;
    d = int'(i[11:10]); a = int'(i[9:8]); bb = int'(i[7:6]);
    if (!i[15]) begin
      push(1'b1, b(GO + a) | b(A1), "ALU_X0");
      push(1'b1, b(GO + bb) | b(A2), "ALU_X1");
      push(1'b1, b(AL), "ALU_X2");
      push(1'b1, b(AO) | b(GI + d), "ALU_X3");
    end else begin
      case (i[14:12])
        3'b000: begin
          push(1'b1, b(GO + a) | b(MAR), "LOAD_X0");
          repeat (wm) push(1'b0, b(MEN) | b(MRW), "LOAD_X1_wait");
          push(1'b1, b(MEN) | b(MRW) | b(MDR), "LOAD_X1");
          push(1'b1, b(MDO) | b(GI + d), "LOAD_X2");
        end
        3'b001: begin
          push(1'b1, b(GO + a) | b(MAR), "STORE_X0");
          push(1'b1, b(GO + bb) | b(MDW), "STORE_X1");
          repeat (wm) push(1'b0, b(MEN), "STORE_X2_wait");
          push(1'b1, b(MEN), "STORE_X2");
        end
        3'b010: push(1'b1, b(P1) | b(GI + d), "IN_X0");
        3'b011: push(1'b1, b(GO + a) | b(P0), "OUT_X0");
        3'b100: push(1'b1, b(IMM) | b(GI + d), "LDI_X0");
        default: ;
      endcase
    end
  endtask

  // Called at a falling edge; leaves the bench at the falling edge after the
  // last queued cycle.
  task automatic drain();
    sb_t s;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      mfc = s.m;
      #1;
      check(s.tag, sample(), s.exp);
      check_bus(s.tag);
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{16'h0640, 0, 0, "alu_0640"};
    vecs[1] = '{16'h0640, 5, 0, "alu_fetch_wait5"};
    vecs[2] = '{16'h9100, 0, 2, "store_wait2"};
    vecs[3] = '{16'hA800, 0, 0, "in"};
    vecs[4] = '{16'h8E00, 0, 1, "load_wait1"};
    vecs[5] = '{16'hB300, 0, 0, "out"};
    vecs[6] = '{16'hC400, 0, 0, "ldi"};
    vecs[7] = '{16'hD000, 0, 0, "nop_101"};
    vecs[8] = '{16'hE000, 0, 0, "nop_110"};
    vecs[9] = '{16'h7BC0, 2, 0, "alu_7bc0"};

    rst = 1'b0; mfc = 1'b1; ir = 16'h0000;
    repeat (3) @(negedge clk);
    #1 check("reset_outputs", sample(), '0);
    rst = 1'b1;
    #1 check("release_before_edge", sample(), '0);
    @(negedge clk);

    foreach (vecs[k]) begin
      ir = vecs[k].ir;
      push_fetch(vecs[k].wf);
      push_exec(vecs[k].ir, vecs[k].wm);
      drain();
      #1 check({"back_to_f0_", vecs[k].name}, sample(), b(PCO) | b(MAR));
    end

    ir = 16'hF000;
    push_fetch(0);
    for (int c = 0; c < 20; c++) push(logic'(c[0]), b(HLT), "HALT");
    drain();
    #1 check("halt_absorbing", sample(), b(HLT));

    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of a LOAD memory wait.
    ir = 16'h8E00;
    push_fetch(0);
    push(1'b1, b(GO + 2) | b(MAR), "LOAD_X0");
    repeat (3) push(1'b0, b(MEN) | b(MRW), "LOAD_X1_wait");
    drain();
    mfc = 1'b0;
    #1 check("abort_pre", sample(), b(MEN) | b(MRW));
    #1 rst = 1'b0;
    #1 check("abort_async_drop", sample(), '0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("abort_release", sample(), '0);
    @(negedge clk);

    ir = vecs[0].ir;
    push_fetch(0);
    push_exec(vecs[0].ir, 0);
    drain();
    #1 check("restart_back_to_f0", sample(), b(PCO) | b(MAR));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
